// File: rtl/a2d_spi_master_if.sv
// Control-side bundle of the A2D SPI master.
// master = conversion requester, slave = a2d_spi_master.
interface a2d_spi_master_if;
  logic        strt;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (
    output strt,
    output chnnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt,
    input  chnnl,
    output cnv_cmplt,
    output res
  );
endinterface

// File: rtl/a2d_spi_master.sv
// SPI master running channel conversions on an ADC128S-style 12-bit A2D.
// Define A2D_SINGLE_FRAME_EN to run each conversion as a single frame.
module a2d_spi_master #(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  a2d_spi_master_if.slave ctl,
  output logic SS_n,
  output logic SCLK,
  output logic MOSI,
  input  logic MISO
);
  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] HLAST = CW'(SCLK_DIV/2 - 1);
  localparam logic [CW-1:0] HALF  = CW'(SCLK_DIV/2);
  localparam logic [CW-1:0] LAST  = CW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FRONT, SHIFT, BACK, GAP, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic          frm_q, frm_d;
  logic [2:0]    chn_q, chn_d;
  logic [15:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic [11:0]   res_q, res_d;
  logic          cmplt_q, cmplt_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;

  function automatic logic [15:0] cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frm_d   = frm_q;
    chn_d   = chn_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    res_d   = res_q;
    cmplt_d = cmplt_q;
    unique case (state_q)
      IDLE: begin
        if (ctl.strt) begin
          state_d = FRONT;
          chn_d   = ctl.chnnl;
          tx_d    = cmd(ctl.chnnl);
          cmplt_d = 1'b0;
          frm_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      FRONT: begin
        if (cnt_q == HLAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        // SCLK rises on this edge: capture MISO
        if (cnt_q == HLAST) begin
          bit_d = bit_q + 5'd1;
          rx_d  = {rx_q[14:0], MISO};
        end
        if (cnt_q == LAST) begin
          if (bit_q == 5'd16) begin
            state_d = BACK;
            bit_d   = '0;
          end else begin
            tx_d = {tx_q[14:0], 1'b0};
          end
        end
      end
      BACK: begin
        if (cnt_q == HLAST) begin
          cnt_d = '0;
`ifdef A2D_SINGLE_FRAME_EN
          state_d = DONE;
`else
          state_d = frm_q ? DONE : GAP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == HLAST) begin
          state_d = FRONT;
          cnt_d   = '0;
          frm_d   = 1'b1;
          tx_d    = cmd(chn_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        res_d   = rx_q[11:0];
        cmplt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // pins follow the next state so they leave straight from flops
    ss_d   = !(state_d inside {FRONT, SHIFT, BACK});
    sclk_d = !(state_d == SHIFT && cnt_d < HALF);
    mosi_d = !ss_d && tx_d[15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frm_q   <= 1'b0;
      chn_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      res_q   <= '0;
      cmplt_q <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      chn_q   <= chn_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      res_q   <= res_d;
      cmplt_q <= cmplt_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign SS_n          = ss_q;
  assign SCLK          = sclk_q;
  assign MOSI          = mosi_q;
  assign ctl.cnv_cmplt = cmplt_q;
  assign ctl.res       = res_q;
endmodule

// File: tb/tb_a2d_spi_master.sv
// Scoreboard bench for a2d_spi_master with a falling-edge-shifting
// A2D slave model; frames and results are checked by a monitor.
module tb_a2d_spi_master;
  localparam int D = 32;
`ifdef A2D_SINGLE_FRAME_EN
  localparam int NF  = 1;
  localparam int LAT = 17*D + 1;
`else
  localparam int NF  = 2;
  localparam int LAT = 34*D + D/2 + 1;
`endif

  typedef struct {
    logic [11:0] res;
    int          lat;
    int          falls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic MISO = 1'b0;
  logic SS_n, SCLK, MOSI;

  a2d_spi_master_if ctl();

  a2d_spi_master #(.SCLK_DIV(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctl  (ctl),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int falls = 0;
  int rises = 0;
  int done_cnt = 0;
  int t_start = 0;
  int f0 = 0;
  logic [11:0] last_res = 12'h000;

  logic [15:0] exp_cmd_q[$];
  exp_t        exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // A2D slave: presents bit 15 on the first SCLK fall, then shifts
  logic [15:0] resp[2];
  logic [15:0] cur = 16'h0;
  logic        fsel = 1'b0;
  int          sidx = 0;

  always @(negedge SS_n) begin
    cur  = resp[fsel];
    fsel = ~fsel;
    sidx = 15;
  end

  always @(negedge SCLK) begin
    if (!SS_n && sidx >= 0) begin
      MISO = cur[sidx];
      sidx--;
    end
  end

  // monitor
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_cmplt = 1'b0;
  logic [15:0] mosi_sr = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ss    = 1'b1;
      prev_sclk  = 1'b1;
      prev_cmplt = 1'b0;
    end else begin
      if (!SS_n && prev_ss) mosi_sr = 16'h0;
      if (!SS_n && !prev_sclk && SCLK) begin
        mosi_sr = {mosi_sr[14:0], MOSI};
        rises++;
      end
      if (!SS_n && prev_sclk && !SCLK) falls++;
      if (SS_n && !prev_ss) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL frame_extra: got frame %h expected none",
                   mosi_sr);
        end else begin
          chk("mosi_frame", {16'h0, mosi_sr}, {16'h0, exp_cmd_q.pop_front()});
        end
      end
      if (ctl.cnv_cmplt && !prev_cmplt) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL done_extra: got res %h expected no completion",
                   ctl.res);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res", {20'h0, ctl.res}, {20'h0, e.res});
          chk("latency", cyc - t_start, e.lat);
          chk("sclk_falls", falls - f0, e.falls);
        end
      end
      prev_ss    = SS_n;
      prev_sclk  = SCLK;
      prev_cmplt = ctl.cnv_cmplt;
    end
  end

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no cnv_cmplt expected one in 4000 clk");
    end
  endtask

  task automatic run(input logic [2:0] ch, input logic [15:0] r1,
                     input logic [15:0] r2, input logic [15:0] ecmd,
                     input logic [11:0] eres, input bit ign);
    int d0;
    exp_t e;
    d0 = done_cnt;
    resp[0] = (NF == 2) ? r1 : r2;
    resp[1] = r2;
    fsel = 1'b0;
    for (int i = 0; i < NF; i++) exp_cmd_q.push_back(ecmd);
    e.res = eres;
    e.lat = LAT;
    e.falls = 16*NF;
    exp_q.push_back(e);
    @(negedge clk);
    ctl.strt = 1'b1;
    ctl.chnnl = ch;
    @(negedge clk);
    ctl.strt = 1'b0;
    ctl.chnnl = 3'd0;
    t_start = cyc;
    f0 = falls;
    chk("cmplt_clr", {31'h0, ctl.cnv_cmplt}, 32'd0);
    chk("res_hold", {20'h0, ctl.res}, {20'h0, last_res});
    if (ign) begin
      repeat (200) @(negedge clk);
      ctl.strt = 1'b1;
      ctl.chnnl = 3'd2;
      @(negedge clk);
      ctl.strt = 1'b0;
      ctl.chnnl = 3'd0;
    end
    wait_done(d0);
    last_res = eres;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r0;
    ctl.strt = 1'b0;
    ctl.chnnl = 3'd0;
    resp[0] = 16'h0;
    resp[1] = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ss_n", {31'h0, SS_n}, 32'd1);
    chk("rst_sclk", {31'h0, SCLK}, 32'd1);
    chk("rst_mosi", {31'h0, MOSI}, 32'd0);
    chk("rst_cmplt", {31'h0, ctl.cnv_cmplt}, 32'd0);
    chk("rst_res", {20'h0, ctl.res}, 32'd0);

    run(3'd5, 16'h5A5A, 16'h0ABC, 16'h2800, 12'hABC, 1'b1);
    run(3'd3, 16'hFFFF, 16'hF123, 16'h1800, 12'h123, 1'b0);
    repeat (100) @(negedge clk);
    chk("hold_cmplt", {31'h0, ctl.cnv_cmplt}, 32'd1);
    chk("hold_res", {20'h0, ctl.res}, 32'h123);
    run(3'd7, 16'h1234, 16'h0FFF, 16'h3800, 12'hFFF, 1'b0);

    // reset with the bit counter at 7
    resp[0] = 16'h0;
    resp[1] = 16'h0;
    fsel = 1'b0;
    @(negedge clk);
    ctl.strt = 1'b1;
    ctl.chnnl = 3'd1;
    @(negedge clk);
    ctl.strt = 1'b0;
    r0 = rises;
    n = 0;
    while (rises - r0 < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rises - r0 < 7) begin
      checks++;
      errs++;
      $display("FAIL mid_wait: got %0d rises expected 7", rises - r0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ss_n", {31'h0, SS_n}, 32'd1);
    chk("mid_sclk", {31'h0, SCLK}, 32'd1);
    chk("mid_mosi", {31'h0, MOSI}, 32'd0);
    chk("mid_cmplt", {31'h0, ctl.cnv_cmplt}, 32'd0);
    chk("mid_res", {20'h0, ctl.res}, 32'd0);
    last_res = 12'h000;
    rst = 1'b0;
    @(negedge clk);

    run(3'd6, 16'h0F0F, 16'h7456, 16'h3000, 12'h456, 1'b0);

    repeat (10) @(negedge clk);
    if (exp_cmd_q.size() != 0 || exp_q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL sb_left: got %0d frames %0d results expected 0",
               exp_cmd_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/a2d_spi_master.md
# a2d_spi_master

SPI master that runs conversions on the ADC128S-style 12-bit, 8-channel A2D converter model. On `strt` it latches a channel and issues the channel command over SPI. It shifts in the converter's response and presents the 12-bit result with a sticky completion flag. It sits between the control logic and the `SS_n/SCLK/MOSI/MISO` pins of the A2D model.

## Interface
- `SCLK_DIV`, default 32: clk cycles per SCLK period. Must be even and ≥ 4.
- `clk` input, 1 bit: system clock. All logic runs on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset. One clock, and reset is asynchronous and active-high.
- `strt` input, 1 bit: start a conversion. Sampled only in IDLE.
- `chnnl` input, 3 bits: channel to convert. Latched on the accepted `strt`.
- `cnv_cmplt` output, 1 bit: conversion complete. Sticky.
- `res` output, 12 bits: last conversion result.
- `SS_n` output, 1 bit: active-low slave select.
- `SCLK` output, 1 bit: serial clock. Idles high.
- `MOSI` output, 1 bit: serial data to the A2D.
- `MISO` input, 1 bit: serial data from the A2D.

## Operation
- Command word: {2'b00, chnnl_latched[2:0], 11'h000}, sent MSB first. Channel occupies bits [13:11].
- A conversion is two back-to-back 16-bit frames with the same command:
  - Frame 1 sets the channel.
  - Frame 2 returns the data.
  - `res` = bits [11:0] shifted in during frame 2. Bits [15:12] are discarded.
- States and transitions:
  - IDLE: `SS_n`=1, `SCLK`=1. On `strt` → FRONT. Latch `chnnl`, clear `cnv_cmplt`, `SS_n`=0, drive `MOSI`=cmd[15].
  - FRONT: SCLK_DIV/2 clk with SCLK high → SHIFT.
  - SHIFT: 16 SCLK periods, each SCLK_DIV clk.
    - SCLK low for the first half of each period, high for the second.
    - `MOSI` advances to the next bit at each SCLK falling edge, except the first (bit 15 is already driven).
    - `MISO` is shifted into a 16-bit register on the clk where SCLK rises.
    - After the 16th rising edge → BACK.
  - BACK: SCLK_DIV/2 clk with SCLK high, then `SS_n`=1.
    - → GAP after frame 1.
    - → DONE after frame 2.
  - GAP: `SS_n` high for SCLK_DIV/2 clk → FRONT of frame 2. `SS_n` drops and `MOSI`=cmd[15] again.
  - DONE: load `res`, set `cnv_cmplt` → IDLE.
- Counters:
  - SCLK divider: $clog2(SCLK_DIV) bits, wraps at SCLK_DIV-1.
  - Bit counter: 5 bits, 0..16.
  - Frame counter: 1 bit.
- `strt` outside IDLE is ignored. `strt` in the same cycle DONE returns to IDLE is not accepted; it is accepted the next cycle.
- `cnv_cmplt` stays high until the next accepted `strt`. `res` holds until the next DONE.
- `MOSI` is 0 whenever `SS_n`=1.

## Timing
- Reset values (any state, including mid-frame): IDLE, `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `res`=12'h000, all counters 0.
- `strt` sampled high at edge 0 → `SS_n` low after edge 0.
- Frame length from `SS_n` fall to `SS_n` rise: 17·SCLK_DIV clk. GAP: SCLK_DIV/2 clk.
- `cnv_cmplt` rises 34·SCLK_DIV + SCLK_DIV/2 + 1 clk after the accepted `strt` (1105 at default).
- All outputs are registered, so no combinational path from `MISO`/`strt` to pins.
- `MISO` is sampled half an SCLK period after the slave's falling-edge shift. This requires the slave to shift on SCLK fall.

## Configuration
- `A2D_SINGLE_FRAME_EN`:
  - Defined: a conversion is one frame. BACK → DONE directly, GAP unused. `res` comes from that frame. Latency 17·SCLK_DIV + 1 clk (545 at default). Use this with A2D models that return the addressed channel in the same frame.
  - Undefined: two-frame behaviour as above.

## Test plan
- Reset mid-SHIFT (assert `rst` with bit counter = 7) → next cycle `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0.
- `chnnl`=3'd5, `strt` pulse, MISO model returns 16'h0ABC in frame 2:
  - `MOSI` stream = 16'h2800 in both frames.
  - 32 SCLK falling edges total.
  - `res`=12'hABC, `cnv_cmplt` high at clk 1105.
- Frame-2 data 16'hF123 → `res`=12'h123 (upper nibble discarded).
- `strt` re-pulsed during frame 1 with `chnnl`=2 → ignored. Command stays channel 5.
- After DONE, hold off `strt` for 100 clk → `cnv_cmplt` stays 1. New `strt` → `cnv_cmplt` 0 the next clk, old `res` retained until the new DONE.
- With `A2D_SINGLE_FRAME_EN`: `chnnl`=3'd7, MISO returns 16'h0FFF → exactly 16 SCLK falls, `res`=12'hFFF, `cnv_cmplt` at clk 545.
